vga_capture: RTL and testbench
==============================

Name: vga_capture

Overview:
- Receive side of the VGA pixel interface. Monitors active-low HSYNC and VSYNC, the BLANK_N valid signal and 24-bit RGB. Captures one complete frame into a 24-bit-per-pixel frame buffer through a simple write port.
- Loopback use: attaches to the VGA output of the display path and writes a frame memory that can be compared against the displayed image file.

Parameters:
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines per frame.
- ADDR_W, 19, write address width. Must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- pix_en  in  1  pixel qualifier, one clk-wide pulse per pixel period. Video inputs are sampled only when pix_en=1.
- start  in  1  arm capture of the next full frame; honoured only in IDLE.
- vga_vsync  in  1  vertical sync, active-low.
- vga_hsync  in  1  horizontal sync, active-low (timing check only).
- vga_blank_n  in  1  1 = visible pixel present on RGB.
- vga_r, vga_g, vga_b  in  8 each  pixel colour.
- wr_en  out  1  frame-buffer write strobe, one clk wide.
- wr_addr  out  ADDR_W  pixel index, y*H_ACTIVE + x.
- wr_data  out  24  {r,g,b}.
- busy  out  1  high in ARM or CAPTURE.
- frame_done  out  1  one-clk pulse at end of a captured frame.
- err  out  1  sticky timing-error flag.

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; x, y, line_base and the sampled sync/blank history cleared. Reset mid-frame abandons the frame with no frame_done.
- Sampling: registers vsync_q and blank_q update only on pix_en=1 cycles. All edges are detected between consecutive pix_en samples.
- States:
  - IDLE: start=1 -> ARM, and err cleared in the same cycle.
  - ARM: waits for a vsync falling edge (vsync_q=1, vga_vsync=0) -> CAPTURE with x=0, y=0, line_base=0.
  - CAPTURE: pixel and line handling below. A vsync falling edge ends the frame -> IDLE.
- Pixel write: on a pix_en cycle in CAPTURE with vga_blank_n=1, x<H_ACTIVE and y<V_ACTIVE:
  - Next cycle: wr_en=1, wr_data={r,g,b}, wr_addr=line_base+x (latency 1 clk).
  - x increments.
  - wr_en is 0 on every other cycle.
- Out-of-range pixel (blank_n=1 with x>=H_ACTIVE or y>=V_ACTIVE): no write; err set.
- Line end (blank_q=1 and vga_blank_n=0 on a pix_en cycle):
  - If x != H_ACTIVE, set err.
  - x=0, y+=1, line_base+=H_ACTIVE.
  - No multiplier is used; line_base width is ADDR_W.
- Frame end (vsync falling edge in CAPTURE):
  - If y != V_ACTIVE, set err.
  - frame_done=1 for one clk; state -> IDLE.
  - If the final pixel write coincides, it still occurs.
- ARM before any vsync falling edge: no writes, even when blank_n=1. This prevents partial frames.
- start while busy: ignored. A start pulse coinciding with frame_done is also ignored because the state is not yet IDLE.
- pix_en=0: no state, counter or edge change. A pending wr_en still deasserts.
- hsync: no effect on addressing. err is set if a hsync falling edge occurs while blank_n=1 in CAPTURE.
- err stays high until the next accepted start or reset.

Test Plan:
- Nominal, with H_ACTIVE=4, V_ACTIVE=3, pix_en every 2nd clk, pixel (x,y) driven as {8'(x),8'(y),8'hA5}:
  - start, then a vsync pulse, then 3 lines of 4 valid pixels, then a vsync falling edge.
  - Expect exactly 12 writes with addr 0..11 in order; data at addr 6 is 24'h0201A5.
  - Expect frame_done a single pulse; err=0; busy falls with frame_done.
- Pre-sync suppression: blank_n=1 traffic after start but before the first vsync falling edge -> zero writes; busy=1.
- Short line: line 1 carries only 3 valid pixels -> err=1 at the line end; addr for line 2 starts at 8; err is still 1 after frame_done.
- Extra line: 4 lines before vsync -> 4th-line pixels not written; err=1; frame_done still pulses.
- Reset mid-frame: rst=0 after 5 writes -> wr_en, busy, frame_done and err drop to 0 immediately. Subsequent traffic without start -> no writes.
- Full size, default parameters, capture of the display path's 640x480 output:
  - 307200 writes; last addr 307199.
  - Memory contents match the source image hex file.
  - err=0.

Source files
------------

// File: rtl/vga_capture.sv
// Receive side of a VGA pixel interface: captures one complete frame into a
// 24-bit-per-pixel frame buffer through a single-cycle write port.
module vga_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_en,
  input  logic              start,
  input  logic              vga_vsync,
  input  logic              vga_hsync,
  input  logic              vga_blank_n,
  input  logic [7:0]        vga_r,
  input  logic [7:0]        vga_g,
  input  logic [7:0]        vga_b,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [23:0]       wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              err
);

  localparam int XW = $clog2(H_ACTIVE + 1);
  // y saturates one past the last line so an extra line is still visible at frame end
  localparam int YW = $clog2(V_ACTIVE + 2);

  // DONE is the single frame_done cycle; start is not honoured there
  typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DONE} state_t;

  state_t            state, state_nx;
  logic              vsync_q, hsync_q, blank_q;
  logic [XW-1:0]     x, x_nx;
  logic [YW-1:0]     y, y_nx;
  logic [ADDR_W-1:0] line_base, line_base_nx;
  logic              err_nx, wr_nx;
  logic              vsync_fall, hsync_fall, line_end, in_range;

  assign vsync_fall = pix_en & vsync_q & ~vga_vsync;
  assign hsync_fall = pix_en & hsync_q & ~vga_hsync;
  assign line_end   = pix_en & blank_q & ~vga_blank_n;
  assign in_range   = (x < XW'(H_ACTIVE)) && (y < YW'(V_ACTIVE));

  // NOTE: every signal assigned below gets a default first, so no latch is inferred.
  always_comb begin
    state_nx     = state;
    x_nx         = x;
    y_nx         = y;
    line_base_nx = line_base;
    err_nx       = err;
    wr_nx        = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = ARM;
          err_nx   = 1'b0;
        end
      end
      ARM: begin
        if (vsync_fall) begin
          state_nx     = CAPTURE;
          x_nx         = '0;
          y_nx         = '0;
          line_base_nx = '0;
        end
      end
      CAPTURE: begin
        if (pix_en && vga_blank_n) begin
          if (in_range) begin
            wr_nx = 1'b1;
            x_nx  = x + XW'(1);
          end else begin
            err_nx = 1'b1;
          end
        end
        if (hsync_fall && vga_blank_n) err_nx = 1'b1;
        if (line_end) begin
          if (x != XW'(H_ACTIVE)) err_nx = 1'b1;
          x_nx = '0;
          if (y <= YW'(V_ACTIVE)) y_nx = y + YW'(1);
          if (y < YW'(V_ACTIVE)) line_base_nx = line_base + ADDR_W'(H_ACTIVE);
        end
        if (vsync_fall) begin
          if (y != YW'(V_ACTIVE)) err_nx = 1'b1;
          state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments under an async active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      vsync_q   <= 1'b0;
      hsync_q   <= 1'b0;
      blank_q   <= 1'b0;
      x         <= '0;
      y         <= '0;
      line_base <= '0;
      err       <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      state     <= state_nx;
      x         <= x_nx;
      y         <= y_nx;
      line_base <= line_base_nx;
      err       <= err_nx;
      wr_en     <= wr_nx;
      if (pix_en) begin
        vsync_q <= vga_vsync;
        hsync_q <= vga_hsync;
        blank_q <= vga_blank_n;
      end
      if (wr_nx) begin
        wr_addr <= line_base + ADDR_W'(x);
        wr_data <= {vga_r, vga_g, vga_b};
      end
    end
  end

  assign busy       = (state == ARM) || (state == CAPTURE);
  assign frame_done = (state == DONE);

endmodule

// File: tb/tb_vga_capture.sv
// Self-checking bench for vga_capture on a 4x3 frame: frames are described as
// line pixel counts and the expected writes/err come from that description.
module tb_vga_capture;

  localparam int H  = 4;
  localparam int V  = 3;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst, pix_en, start, vga_vsync, vga_hsync, vga_blank_n;
  logic [7:0]    vga_r, vga_g, vga_b;
  logic          wr_en, busy, frame_done, err;
  logic [AW-1:0] wr_addr;
  logic [23:0]   wr_data;

  vga_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .start(start),
    .vga_vsync(vga_vsync), .vga_hsync(vga_hsync), .vga_blank_n(vga_blank_n),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .frame_done(frame_done), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // observed traffic
  int          got_addr[$];
  logic [23:0] got_data[$];
  int          done_cnt;
  logic        busy_prev, busy_at_done, prev_at_done;

  // reference model output
  int          exp_addr[$];
  logic [23:0] exp_data[$];
  bit          exp_err;
  bit          err_line[8];

  // frame description
  int line_cnt[8];
  int n_lines;
  bit use_pattern;
  bit rand_gap;
  int abort_after;
  int mid_start_line;

  always @(negedge clk) begin
    if (wr_en) begin
      got_addr.push_back(int'(wr_addr));
      got_data.push_back(wr_data);
    end
    if (frame_done) begin
      done_cnt++;
      busy_at_done = busy;
      prev_at_done = busy_prev;
    end
    busy_prev = busy;
  end

  task automatic clear_mon();
    got_addr.delete();
    got_data.delete();
    done_cnt = 0;
  endtask

  task automatic pix(input logic vs, input logic hs, input logic bn, input logic [23:0] rgb);
    @(posedge clk); #1;
    vga_vsync = vs; vga_hsync = hs; vga_blank_n = bn;
    {vga_r, vga_g, vga_b} = rgb;
    pix_en = 1'b1;
    @(posedge clk); #1;
    pix_en = 1'b0;
    if (rand_gap) repeat ($urandom_range(0, 2)) @(posedge clk);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0; pix_en = 1'b0; start = 1'b0;
    vga_vsync = 1'b1; vga_hsync = 1'b1; vga_blank_n = 1'b0;
    vga_r = 8'h0; vga_g = 8'h0; vga_b = 8'h0;
    use_pattern = 1'b1; rand_gap = 1'b0; abort_after = 0; mid_start_line = -1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    clear_mon();
  endtask

  // Drives vsync pulse, n_lines lines and a closing vsync edge; builds expectations:
  // pixel k of line l lands at l*H+k only when l<V and k<H, any deviation flags err.
  task automatic drive_frame();
    logic [23:0] d;
    exp_addr.delete();
    exp_data.delete();
    exp_err = (n_lines != V);
    pix(1, 1, 0, 0); pix(0, 1, 0, 0); pix(0, 1, 0, 0); pix(1, 1, 0, 0);
    for (int l = 0; l < n_lines; l++) begin
      if (l == mid_start_line) pulse_start();
      if (line_cnt[l] != H) exp_err = 1'b1;
      pix(1, 0, 0, 0); pix(1, 1, 0, 0);
      for (int k = 0; k < line_cnt[l]; k++) begin
        d = use_pattern ? {8'(k), 8'(l), 8'hA5} : 24'($urandom);
        if (l < V && k < H) begin
          exp_addr.push_back(l * H + k);
          exp_data.push_back(d);
        end
        pix(1, 1, 1, d);
        if (abort_after > 0 && exp_addr.size() >= abort_after) return;
      end
      pix(1, 1, 0, 0);
      err_line[l] = err;
    end
    pix(0, 1, 0, 0); pix(1, 1, 0, 0); pix(1, 1, 0, 0);
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({wr_en, busy, frame_done, err} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got=%b want=0000", {wr_en, busy, frame_done, err});
    end
    total++;
    if ({wr_addr, wr_data} !== '0) begin
      bad++; $display("FAIL reset_bus got addr=%0d data=%h want 0", wr_addr, wr_data);
    end
  endtask

  task automatic test_nominal();
    do_reset();
    pulse_start();
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL nominal_busy_armed got=%b want=1", busy); end
    n_lines = V;
    for (int l = 0; l < V; l++) line_cnt[l] = H;
    drive_frame();
    total++;
    if (got_addr.size() != exp_addr.size()) begin
      bad++; $display("FAIL nominal_count got=%0d want=%0d", got_addr.size(), exp_addr.size());
    end else begin
      for (int i = 0; i < exp_addr.size(); i++) begin
        total++;
        if (got_addr[i] != exp_addr[i] || got_data[i] !== exp_data[i]) begin
          bad++; $display("FAIL nominal_write[%0d] got=%0d/%h want=%0d/%h",
                          i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
        end
      end
      total++;
      if (got_data[6] !== 24'h0201A5) begin
        bad++; $display("FAIL nominal_addr6 got=%h want=0201a5", got_data[6]);
      end
    end
    total++;
    if (done_cnt != 1) begin bad++; $display("FAIL nominal_done got=%0d want=1", done_cnt); end
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL nominal_err got=%b want=0", err); end
    total++;
    if (busy_at_done !== 1'b0 || prev_at_done !== 1'b1) begin
      bad++; $display("FAIL nominal_busy_fall got at=%b before=%b want 0/1", busy_at_done, prev_at_done);
    end
  endtask

  task automatic test_presync();
    do_reset();
    pulse_start();
    for (int i = 0; i < 6; i++) pix(1, (i % 3) != 0, 1, 24'($urandom));
    total++;
    if (got_addr.size() != 0) begin bad++; $display("FAIL presync_writes got=%0d want=0", got_addr.size()); end
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL presync_busy got=%b want=1", busy); end
  endtask

  task automatic test_short_line();
    do_reset();
    pulse_start();
    n_lines = V;
    line_cnt[0] = H; line_cnt[1] = H - 1; line_cnt[2] = H;
    mid_start_line = 2;
    drive_frame();
    total++;
    if (err_line[0] !== 1'b0 || err_line[1] !== 1'b1) begin
      bad++; $display("FAIL short_err_at_line got=%b%b want=01", err_line[0], err_line[1]);
    end
    total++;
    if (got_addr.size() != exp_addr.size()) begin
      bad++; $display("FAIL short_count got=%0d want=%0d", got_addr.size(), exp_addr.size());
    end else begin
      for (int i = 0; i < exp_addr.size(); i++) begin
        total++;
        if (got_addr[i] != exp_addr[i] || got_data[i] !== exp_data[i]) begin
          bad++; $display("FAIL short_write[%0d] got=%0d/%h want=%0d/%h",
                          i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
        end
      end
      total++;
      if (got_addr[7] != 8) begin bad++; $display("FAIL short_line2_base got=%0d want=8", got_addr[7]); end
    end
    total++;
    if (err !== 1'b1 || done_cnt != 1) begin
      bad++; $display("FAIL short_after_done got err=%b done=%0d want 1/1", err, done_cnt);
    end
  endtask

  task automatic test_extra_line();
    do_reset();
    pulse_start();
    n_lines = V + 1;
    for (int l = 0; l < n_lines; l++) line_cnt[l] = H;
    drive_frame();
    total++;
    if (got_addr.size() != exp_addr.size()) begin
      bad++; $display("FAIL extra_count got=%0d want=%0d", got_addr.size(), exp_addr.size());
    end else begin
      for (int i = 0; i < exp_addr.size(); i++) begin
        total++;
        if (got_addr[i] != exp_addr[i] || got_data[i] !== exp_data[i]) begin
          bad++; $display("FAIL extra_write[%0d] got=%0d/%h want=%0d/%h",
                          i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
        end
      end
    end
    total++;
    if (err !== exp_err || done_cnt != 1) begin
      bad++; $display("FAIL extra_status got err=%b done=%0d want %b/1", err, done_cnt, exp_err);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    pulse_start();
    n_lines = V;
    line_cnt[0] = H - 1; line_cnt[1] = H; line_cnt[2] = H;
    abort_after = 5;
    drive_frame();
    total++;
    if ({wr_en, busy, err} !== 3'b111) begin
      bad++; $display("FAIL midrst_before got wr/busy/err=%b want=111", {wr_en, busy, err});
    end
    rst = 1'b0;
    #1;
    total++;
    if ({wr_en, busy, frame_done, err} !== 4'b0000) begin
      bad++; $display("FAIL midrst_drop got=%b want=0000", {wr_en, busy, frame_done, err});
    end
    @(negedge clk) rst = 1'b1;
    clear_mon();
    abort_after = 0;
    line_cnt[0] = H;
    drive_frame();
    total++;
    if (got_addr.size() != 0 || done_cnt != 0 || busy !== 1'b0) begin
      bad++; $display("FAIL midrst_nostart got writes=%0d done=%0d busy=%b want 0/0/0",
                      got_addr.size(), done_cnt, busy);
    end
  endtask

  task automatic test_random();
    do_reset();
    use_pattern = 1'b0;
    rand_gap = 1'b1;
    for (int f = 0; f < 6; f++) begin
      pulse_start();
      clear_mon();
      n_lines = (f < 2) ? V : $urandom_range(V - 1, V + 1);
      for (int l = 0; l < n_lines; l++)
        line_cnt[l] = (f < 2) ? H : $urandom_range(H - 1, H + 1);
      drive_frame();
      total++;
      if (got_addr.size() != exp_addr.size()) begin
        bad++; $display("FAIL rand%0d_count got=%0d want=%0d", f, got_addr.size(), exp_addr.size());
      end else begin
        for (int i = 0; i < exp_addr.size(); i++) begin
          total++;
          if (got_addr[i] != exp_addr[i] || got_data[i] !== exp_data[i]) begin
            bad++; $display("FAIL rand%0d_write[%0d] got=%0d/%h want=%0d/%h",
                            f, i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
          end
        end
      end
      total++;
      if (err !== exp_err || done_cnt != 1 || busy !== 1'b0) begin
        bad++; $display("FAIL rand%0d_status got err=%b done=%0d busy=%b want %b/1/0",
                        f, err, done_cnt, busy, exp_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_presync();
    test_short_line();
    test_extra_line();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
